// File: rtl/cpu_arb_pkg.sv
// rtl/cpu_arb_pkg.sv - shared state encoding and width helper for the round-robin arbiter
package cpu_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits for tiny N.
    function automatic int clog2_safe(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating first-set picker starting at ptr
module rr_pick
    import cpu_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_safe(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;

    // ptr is always < N, so a single conditional subtract is an exact mod N.
    function automatic int wrap(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[wrap(i + int'(ptr))];
        end

        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IW'(i);
            end
        end

        idx    = IW'(wrap(int'(off) + int'(ptr)));
        onehot = '0;
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter holding grant until release; optional hold limit under ARB_TIMEOUT_EN
module rr_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IW       = clog2_safe(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          rel,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          any_req,
    output logic          timeout
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    arb_state_e    state;
    logic [IW-1:0] ptr;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_onehot;
    logic          hold_expire;
    logic          owner_done;
    logic          grant_exit;
    logic [IW-1:0] next_ptr;

    assign any_req = |req;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // A dropped request from the owner ends the grant exactly like release.
    assign owner_done = rel | ~req[gnt_id];
    assign grant_exit = (state == ARB_GRANT) & (owner_done | hold_expire);
    assign next_ptr   = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt;

    // Counter reads k-1 during the k-th granted cycle, so expiry lands on cycle MAX_HOLD.
    assign hold_expire = (state == ARB_GRANT) && (hold_cnt == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= hold_expire & ~owner_done;
            if (state != ARB_GRANT || grant_exit) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign hold_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        gnt       <= pick_onehot;
                        gnt_id    <= pick_idx;
                        gnt_valid <= 1'b1;
                        state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (grant_exit) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                        ptr       <= next_ptr;
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
